instr_sequencer: RTL and testbench

//  Fetch/decode/execute controller for the demo computer. Steps pc over the instruction

---
 rtl/comp_pkg.sv | 34 +++
 rtl/instr_decode.sv | 29 ++
 rtl/instr_sequencer.sv | 128 ++++++++++++
 tb/tb_instr_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared types and widths for the demo computer sequencer
`ifndef F_ADD
`define F_ADD 5'b00001
`endif
`ifndef F_SUB
`define F_SUB 5'b00010
`endif

package comp_pkg;

    localparam int INSTR_W = 8;
    localparam int IMM_W   = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_OUT = 4'h4,
        OP_JMP = 4'h5,
        OP_JZ  = 4'h6,
        OP_HLT = 4'h7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational instruction word decoder
`ifndef F_ADD
`define F_ADD 5'b00001
`endif
`ifndef F_SUB
`define F_SUB 5'b00010
`endif

module instr_decode
    import comp_pkg::*;
(
    input  logic [INSTR_W-1:0] i_ir,
    output opcode_t            o_opcode,
    output logic [IMM_W-1:0]   o_imm,
    output logic               o_is_alu,
    output logic               o_is_jump,
    output logic [4:0]         o_alu_cmd
);

    always_comb begin
        o_imm    = i_ir[IMM_W-1:0];
        // Opcodes 8..F are reserved and behave as NOP
        o_opcode = i_ir[7] ? OP_NOP : opcode_t'(i_ir[7:4]);
        o_is_alu  = (o_opcode == OP_ADD) || (o_opcode == OP_SUB);
        o_is_jump = (o_opcode == OP_JMP) || (o_opcode == OP_JZ);
        o_alu_cmd = (o_opcode == OP_SUB) ? `F_SUB : `F_ADD;
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute controller; SEQ_SINGLE_STEP_EN adds step_btn
`ifndef F_ADD
`define F_ADD 5'b00001
`endif
`ifndef F_SUB
`define F_SUB 5'b00010
`endif

module instr_sequencer
    import comp_pkg::*;
#(
    parameter int N        = 8,
    parameter int MEM_SIZE = 8
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               step_tick,
    input  logic               run_en,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic               step_btn,
`endif
    output logic [N-1:0]       mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [4:0]         alu_cmd,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    input  logic [3:0]         alu_result,
    output logic [3:0]         disp_val,
    output logic               busy,
    output logic               halted
);

    seq_state_t         r_state;
    logic [N-1:0]       r_pc;
    logic [3:0]         r_acc;
    logic [INSTR_W-1:0] r_ir;
    logic [3:0]         r_res;
    logic [3:0]         r_disp;
    logic [4:0]         r_alu_cmd;
    logic [3:0]         r_alu_a;
    logic [3:0]         r_alu_b;

    opcode_t            w_opcode;
    logic [IMM_W-1:0]   w_imm;
    logic               w_is_alu;
    logic               w_is_jump;
    logic [4:0]         w_alu_cmd;
    logic               w_start;
    logic [N-1:0]       w_pc_inc;
    logic [N-1:0]       w_target;

    instr_decode u_decode (
        .i_ir      (r_ir),
        .o_opcode  (w_opcode),
        .o_imm     (w_imm),
        .o_is_alu  (w_is_alu),
        .o_is_jump (w_is_jump),
        .o_alu_cmd (w_alu_cmd)
    );

`ifdef SEQ_SINGLE_STEP_EN
    assign w_start = run_en ? step_tick : step_btn;
`else
    assign w_start = run_en && step_tick;
`endif

    assign w_pc_inc = (r_pc == N'(MEM_SIZE - 1)) ? '0 : r_pc + N'(1);
    assign w_target = ({{(32-IMM_W){1'b0}}, w_imm} >= 32'(MEM_SIZE)) ? '0 : N'(w_imm);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= '0;
            r_acc     <= '0;
            r_ir      <= '0;
            r_res     <= '0;
            r_disp    <= '0;
            r_alu_cmd <= `F_ADD;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_start) r_state <= ST_FETCH;
                ST_FETCH: begin
                    r_ir    <= mem_data;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_alu_cmd <= w_alu_cmd;
                    r_alu_a   <= r_acc;
                    r_alu_b   <= w_imm;
                    r_state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_res   <= alu_result;
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    // Any tick seen here is dropped: WB always returns to IDLE
                    r_state <= ST_IDLE;
                    r_pc    <= w_pc_inc;
                    if (w_is_alu) r_acc <= r_res;
                    if (w_is_jump && ((w_opcode == OP_JMP) || (r_acc == '0))) r_pc <= w_target;
                    case (w_opcode)
                        OP_LDI:  r_acc  <= w_imm;
                        OP_OUT:  r_disp <= r_acc;
                        OP_HLT: begin
                            r_pc    <= r_pc;
                            r_state <= ST_HALT;
                        end
                        default: ;
                    endcase
                end
                ST_HALT:   r_state <= ST_HALT;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr = r_pc;
    assign alu_cmd  = r_alu_cmd;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign disp_val = r_disp;
    assign busy     = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
`ifndef F_ADD
`define F_ADD 5'b00001
`endif
`ifndef F_SUB
`define F_SUB 5'b00010
`endif

module tb_instr_sequencer;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       step_tick;
    logic       run_en;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step_btn;
`endif
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [4:0] alu_cmd;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_result;
    logic [3:0] disp_val;
    logic       busy;
    logic       halted;

    logic [7:0] mem [0:255];
    int n_cmp = 0;
    int n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    assign mem_data   = mem[mem_addr];
    assign alu_result = (alu_cmd == `F_SUB) ? 4'(alu_a - alu_b) : 4'(alu_a + alu_b);

    instr_sequencer #(.N(8), .MEM_SIZE(8)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .step_tick  (step_tick),
        .run_en     (run_en),
`ifdef SEQ_SINGLE_STEP_EN
        .step_btn   (step_btn),
`endif
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .alu_cmd    (alu_cmd),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .disp_val   (disp_val),
        .busy       (busy),
        .halted     (halted)
    );

    task automatic clk_n(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step_tick = 1'b0;
        run_en = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        step_btn = 1'b0;
`endif
        clk_n(2);
        rst_n = 1'b1;
    endtask

    task automatic tick_run();
        step_tick = 1'b1;
        clk_n(1);
        step_tick = 1'b0;
        clk_n(5);
    endtask

    task automatic test_reset();
        clear_mem();
        do_reset();
        n_cmp++; if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", mem_addr); end
        n_cmp++; if (disp_val !== 4'd0) begin n_fail++; $display("FAIL reset_disp: got %0d want 0", disp_val); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (alu_cmd !== `F_ADD) begin n_fail++; $display("FAIL reset_alu_cmd: got %h want %h", alu_cmd, `F_ADD); end
        n_cmp++; if ({alu_a, alu_b} !== 8'h00) begin n_fail++; $display("FAIL reset_alu_ops: got %h want 00", {alu_a, alu_b}); end
    endtask

    task automatic test_program();
        clear_mem();
        mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'h40; mem[3] = 8'h70;
        do_reset();
        repeat (4) tick_run();
        n_cmp++; if (disp_val !== 4'd8) begin n_fail++; $display("FAIL prog_disp: got %0d want 8", disp_val); end
        n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL prog_halted: got %b want 1", halted); end
        n_cmp++; if (mem_addr !== 8'd3) begin n_fail++; $display("FAIL prog_pc: got %0d want 3", mem_addr); end
        repeat (2) tick_run();
        n_cmp++; if ({disp_val, mem_addr} !== {4'd8, 8'd3}) begin n_fail++; $display("FAIL halt_hold: got disp %0d pc %0d want 8 3", disp_val, mem_addr); end
        n_cmp++; if ({halted, busy} !== 2'b10) begin n_fail++; $display("FAIL halt_flags: got %b want 10", {halted, busy}); end
    endtask

    task automatic test_sub_wrap();
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h31; mem[2] = 8'h40;
        do_reset();
        repeat (2) tick_run();
        n_cmp++; if (alu_cmd !== `F_SUB) begin n_fail++; $display("FAIL sub_cmd: got %h want %h", alu_cmd, `F_SUB); end
        tick_run();
        n_cmp++; if (disp_val !== 4'd15) begin n_fail++; $display("FAIL sub_wrap: got %0d want 15", disp_val); end
    endtask

    task automatic test_add_wrap();
        clear_mem();
        mem[0] = 8'h1F; mem[1] = 8'h40; mem[2] = 8'h21; mem[3] = 8'h40;
        do_reset();
        repeat (2) tick_run();
        n_cmp++; if (disp_val !== 4'd15) begin n_fail++; $display("FAIL ldi15_out: got %0d want 15", disp_val); end
        repeat (2) tick_run();
        n_cmp++; if (disp_val !== 4'd0) begin n_fail++; $display("FAIL add_wrap: got %0d want 0", disp_val); end
    endtask

    task automatic test_pc_wrap();
        logic [7:0] exp_pc;
        clear_mem();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tick_run();
            exp_pc = 8'((i + 1) % 8);
            n_cmp++; if (mem_addr !== exp_pc) begin n_fail++; $display("FAIL pc_wrap[%0d]: got %0d want %0d", i, mem_addr, exp_pc); end
        end
    endtask

    task automatic test_jumps();
        clear_mem();
        mem[2] = 8'h5C;
        do_reset();
        repeat (3) tick_run();
        n_cmp++; if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL jmp_oob: got %0d want 0", mem_addr); end
        clear_mem();
        mem[0] = 8'h55;
        do_reset();
        tick_run();
        n_cmp++; if (mem_addr !== 8'd5) begin n_fail++; $display("FAIL jmp5: got %0d want 5", mem_addr); end
        clear_mem();
        mem[0] = 8'h66;
        do_reset();
        tick_run();
        n_cmp++; if (mem_addr !== 8'd6) begin n_fail++; $display("FAIL jz_taken: got %0d want 6", mem_addr); end
        clear_mem();
        mem[0] = 8'h13; mem[1] = 8'h66;
        do_reset();
        repeat (2) tick_run();
        n_cmp++; if (mem_addr !== 8'd2) begin n_fail++; $display("FAIL jz_not_taken: got %0d want 2", mem_addr); end
    endtask

    task automatic test_latency();
        clear_mem();
        mem[0] = 8'h29; mem[1] = 8'h40;
        do_reset();
        step_tick = 1'b1;
        clk_n(1);
        step_tick = 1'b0;
        n_cmp++; if ({busy, mem_addr} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL lat_busy: got busy %b pc %0d want 1 0", busy, mem_addr); end
        clk_n(2);
        n_cmp++; if ({alu_cmd, alu_a, alu_b} !== {`F_ADD, 4'd0, 4'd9}) begin n_fail++; $display("FAIL lat_decode: got %h want %h", {alu_cmd, alu_a, alu_b}, {`F_ADD, 4'd0, 4'd9}); end
        clk_n(1);
        n_cmp++; if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL lat_early: got pc %0d want 0", mem_addr); end
        clk_n(1);
        n_cmp++; if ({busy, mem_addr} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL lat_wb: got busy %b pc %0d want 0 1", busy, mem_addr); end
        tick_run();
        n_cmp++; if (disp_val !== 4'd9) begin n_fail++; $display("FAIL lat_acc: got %0d want 9", disp_val); end
    endtask

    task automatic test_back_to_back();
        clear_mem();
        do_reset();
        step_tick = 1'b1;
        clk_n(5);
        step_tick = 1'b0;
        clk_n(2);
        n_cmp++; if ({busy, mem_addr} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL b2b_one: got busy %b pc %0d want 0 1", busy, mem_addr); end
    endtask

    task automatic test_run_en();
        clear_mem();
        mem[0] = 8'h17; mem[1] = 8'h40;
        do_reset();
        run_en = 1'b0;
        repeat (3) tick_run();
        n_cmp++; if ({busy, mem_addr, disp_val} !== {1'b0, 8'd0, 4'd0}) begin n_fail++; $display("FAIL pause: got busy %b pc %0d disp %0d want 0 0 0", busy, mem_addr, disp_val); end
        run_en = 1'b1;
        repeat (2) tick_run();
        n_cmp++; if (disp_val !== 4'd7) begin n_fail++; $display("FAIL resume: got %0d want 7", disp_val); end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'h40;
        do_reset();
        tick_run();
        step_tick = 1'b1;
        clk_n(1);
        step_tick = 1'b0;
        clk_n(2);
        n_cmp++; if ({alu_a, alu_b} !== {4'd5, 4'd3}) begin n_fail++; $display("FAIL mid_ops: got %h want 53", {alu_a, alu_b}); end
        rst_n = 1'b0;
        clk_n(1);
        n_cmp++; if ({mem_addr, disp_val, busy, halted} !== {8'd0, 4'd0, 2'b00}) begin n_fail++; $display("FAIL mid_reset: got pc %0d disp %0d busy %b halted %b", mem_addr, disp_val, busy, halted); end
        n_cmp++; if ({alu_cmd, alu_a, alu_b} !== {`F_ADD, 8'h00}) begin n_fail++; $display("FAIL mid_reset_alu: got %h want %h", {alu_cmd, alu_a, alu_b}, {`F_ADD, 8'h00}); end
        rst_n = 1'b1;
        mem[0] = 8'h40;
        tick_run();
        n_cmp++; if (disp_val !== 4'd0) begin n_fail++; $display("FAIL mid_acc: got %0d want 0", disp_val); end
    endtask

    task automatic test_single_step();
        clear_mem();
        do_reset();
        run_en = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step_btn = 1'b1;
        clk_n(1);
        step_btn = 1'b0;
        clk_n(6);
        n_cmp++; if (mem_addr !== 8'd1) begin n_fail++; $display("FAIL step_btn: got %0d want 1", mem_addr); end
`else
        tick_run();
        n_cmp++; if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL step_none: got %0d want 0", mem_addr); end
`endif
        run_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        step_tick = 1'b0;
        run_en = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        step_btn = 1'b0;
`endif
        test_reset();
        test_program();
        test_sub_wrap();
        test_add_wrap();
        test_pc_wrap();
        test_jumps();
        test_latency();
        test_back_to_back();
        test_run_en();
        test_reset_mid();
        test_single_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
